// File: rtl/multicycle_cu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU/write-select
// codes, FSM states and instruction field offsets.
package multicycle_cu_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_SW  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_NOP = 3'b100;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_PASS_A = 2'b10;
  localparam logic [1:0] ALU_PASS_B = 2'b11;

  localparam logic WSEL_ALU = 1'b0;
  localparam logic WSEL_MEM = 1'b1;

  localparam int OP_LSB  = 0;
  localparam int OP_W    = 3;
  localparam int RD_LSB  = 3;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 13;
  localparam int IMM_LSB = 18;

  typedef enum logic [2:0] {
    IDLE, DECODE, EXEC, MEM_RD, MEM_WR, WB
  } state_t;

  typedef enum logic [2:0] {
    CLS_LW, CLS_SW, CLS_ADD, CLS_SUB, CLS_NOP, CLS_ILL
  } op_class_t;

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational field extraction and opcode classification for the latched
// instruction word.
module cu_decoder
  import multicycle_cu_pkg::*;
#(
  parameter int INSTR_W   = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic [INSTR_W-1:0]         instruction,
  output op_class_t                  op_class,
  output logic [RF_ADDR_W-1:0]       rd,
  output logic [RF_ADDR_W-1:0]       rs1,
  output logic [RF_ADDR_W-1:0]       rs2,
  output logic [INSTR_W-IMM_LSB-1:0] imm,
  output logic                       illegal
);

  logic [OP_W-1:0] op;

  assign op  = instruction[OP_LSB +: OP_W];
  assign rd  = instruction[RD_LSB +: RF_ADDR_W];
  assign rs1 = instruction[RS1_LSB +: RF_ADDR_W];
  assign rs2 = instruction[RS2_LSB +: RF_ADDR_W];
  assign imm = instruction[INSTR_W-1:IMM_LSB];

  always_comb begin
    op_class = CLS_ILL;
    illegal  = 1'b0;
    case (op)
      OP_LW:   op_class = CLS_LW;
      OP_SW:   op_class = CLS_SW;
      OP_ADD:  op_class = CLS_ADD;
      OP_SUB:  op_class = CLS_SUB;
      OP_NOP:  op_class = CLS_NOP;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: accepts one instruction per handshake and walks it
// through DECODE / EXEC / MEM / WB, driving registered RF, DM and ALU controls.
module multicycle_control_unit
  import multicycle_cu_pkg::*;
#(
  parameter int INSTR_W   = 32,
  parameter int RF_ADDR_W = 5,
  parameter int DM_ADDR_W = 5,
  parameter int ZERO_REG  = 1,
  parameter int RET_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [INSTR_W-1:0]   instruction,
  output logic [RF_ADDR_W-1:0] rf_addr_a,
  output logic [RF_ADDR_W-1:0] rf_addr_b,
  output logic                 rf_write_enable,
  output logic [RF_ADDR_W-1:0] rf_write_addr,
  output logic                 rf_wdata_sel,
  output logic                 dm_write_enable,
  output logic                 dm_read,
  output logic [DM_ADDR_W-1:0] dm_addr,
  output logic [1:0]           alu_op,
  output logic                 done,
  output logic                 illegal,
  output logic [RET_CNT_W-1:0] retired_cnt
);

  localparam int IMM_W = INSTR_W - IMM_LSB;

  state_t                 state, state_n;
  logic [INSTR_W-1:0]     instr_q;
  op_class_t              dec_class;
  logic [RF_ADDR_W-1:0]   dec_rd, dec_rs1, dec_rs2;
  logic [IMM_W-1:0]       dec_imm;
  logic                   dec_illegal;
  logic                   unused_imm;

  logic                   accept;
  logic [RF_ADDR_W-1:0]   addr_a_n, addr_b_n, waddr_n;
  logic                   rf_we_n, wsel_n, dm_we_n, dm_rd_n, done_n, ill_n;
  logic [DM_ADDR_W-1:0]   dm_addr_n;
  logic [1:0]             alu_n;

  cu_decoder #(
    .INSTR_W  (INSTR_W),
    .RF_ADDR_W(RF_ADDR_W)
  ) u_dec (
    .instruction(instr_q),
    .op_class   (dec_class),
    .rd         (dec_rd),
    .rs1        (dec_rs1),
    .rs2        (dec_rs2),
    .imm        (dec_imm),
    .illegal    (dec_illegal)
  );

  // Only the low DM_ADDR_W immediate bits address memory.
  assign unused_imm = ^dec_imm;

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    addr_a_n  = rf_addr_a;
    addr_b_n  = rf_addr_b;
    rf_we_n   = 1'b0;
    waddr_n   = '0;
    wsel_n    = WSEL_ALU;
    dm_we_n   = 1'b0;
    dm_rd_n   = 1'b0;
    dm_addr_n = '0;
    alu_n     = ALU_ADD;
    done_n    = 1'b0;
    ill_n     = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid && instr_ready) begin
          accept  = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        addr_a_n = dec_rs1;
        addr_b_n = dec_rs2;
        if (dec_illegal) begin
          ill_n   = 1'b1;
          state_n = IDLE;
        end else begin
          case (dec_class)
            CLS_LW:           state_n = MEM_RD;
            CLS_SW:           state_n = MEM_WR;
            CLS_ADD, CLS_SUB: state_n = EXEC;
            default: begin
              done_n  = 1'b1;
              state_n = IDLE;
            end
          endcase
        end
      end
      MEM_RD: begin
        dm_rd_n   = 1'b1;
        dm_addr_n = dec_imm[DM_ADDR_W-1:0];
        state_n   = WB;
      end
      MEM_WR: begin
        dm_we_n   = 1'b1;
        dm_addr_n = dec_imm[DM_ADDR_W-1:0];
        alu_n     = ALU_PASS_B;
        done_n    = 1'b1;
        state_n   = IDLE;
      end
      EXEC: begin
        alu_n   = (dec_class == CLS_SUB) ? ALU_SUB : ALU_ADD;
        state_n = WB;
      end
      WB: begin
        rf_we_n = !((ZERO_REG != 0) && (dec_rd == '0));
        waddr_n = dec_rd;
        wsel_n  = (dec_class == CLS_LW) ? WSEL_MEM : WSEL_ALU;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      instr_q         <= '0;
      instr_ready     <= 1'b1;
      rf_addr_a       <= '0;
      rf_addr_b       <= '0;
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_wdata_sel    <= WSEL_ALU;
      dm_write_enable <= 1'b0;
      dm_read         <= 1'b0;
      dm_addr         <= '0;
      alu_op          <= ALU_ADD;
      done            <= 1'b0;
      illegal         <= 1'b0;
      retired_cnt     <= '0;
    end else begin
      state           <= state_n;
      if (accept) instr_q <= instruction;
      instr_ready     <= (state_n == IDLE);
      rf_addr_a       <= addr_a_n;
      rf_addr_b       <= addr_b_n;
      rf_write_enable <= rf_we_n;
      rf_write_addr   <= waddr_n;
      rf_wdata_sel    <= wsel_n;
      dm_write_enable <= dm_we_n;
      dm_read         <= dm_rd_n;
      dm_addr         <= dm_addr_n;
      alu_op          <= alu_n;
      done            <= done_n;
      illegal         <= ill_n;
      if (done_n) retired_cnt <= retired_cnt + RET_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: stimulus pushes expected output snapshots tagged with the
// cycle they must appear in; a negedge monitor pops and compares them.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       ready;
    logic [4:0] a;
    logic [4:0] b;
    logic       rf_we;
    logic [4:0] waddr;
    logic       wsel;
    logic       dm_we;
    logic       dm_rd;
    logic [4:0] dm_addr;
    logic [1:0] alu;
    logic       done;
    logic       ill;
    logic [15:0] cnt;
  } snap_t;

  typedef struct {
    string name;
    int    cyc;
    snap_t s;
  } exp_t;

  logic        clk, rst;
  logic        instr_valid, instr_ready;
  logic [31:0] instruction;
  logic [4:0]  rf_addr_a, rf_addr_b, rf_write_addr, dm_addr;
  logic        rf_write_enable, rf_wdata_sel, dm_write_enable, dm_read;
  logic [1:0]  alu_op;
  logic        done, illegal;
  logic [15:0] retired_cnt;

  logic        w_valid, w_ready;
  logic [31:0] w_instr;
  logic [4:0]  w_a, w_b, w_waddr, w_dm_addr;
  logic        w_we, w_wsel, w_dm_we, w_dm_rd;
  logic [1:0]  w_alu;
  logic        w_done, w_ill;
  logic [1:0]  w_cnt;

  int    cyc;
  int    checks, errors;
  exp_t  exp_q[$];
  int    wq[$];
  int    w_last;
  snap_t act;
  bit    end_req, drv_timeout, ended;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_wdata_sel(rf_wdata_sel), .dm_write_enable(dm_write_enable),
    .dm_read(dm_read), .dm_addr(dm_addr), .alu_op(alu_op), .done(done),
    .illegal(illegal), .retired_cnt(retired_cnt)
  );

  multicycle_control_unit #(.RET_CNT_W(2)) dut_wrap (
    .clk(clk), .rst(rst), .instr_valid(w_valid), .instr_ready(w_ready),
    .instruction(w_instr), .rf_addr_a(w_a), .rf_addr_b(w_b),
    .rf_write_enable(w_we), .rf_write_addr(w_waddr),
    .rf_wdata_sel(w_wsel), .dm_write_enable(w_dm_we),
    .dm_read(w_dm_rd), .dm_addr(w_dm_addr), .alu_op(w_alu), .done(w_done),
    .illegal(w_ill), .retired_cnt(w_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    return {14'(imm), 5'(rs2), 5'(rs1), 5'(rd), 3'(op)};
  endfunction

  function automatic snap_t mk(input int ready, input int a, input int b, input int we,
                               input int waddr, input int wsel, input int dm_we,
                               input int dm_rd, input int dm_addr, input int alu,
                               input int dn, input int ill, input int cnt);
    snap_t s;
    s.ready = 1'(ready);   s.a = 5'(a);         s.b = 5'(b);
    s.rf_we = 1'(we);      s.waddr = 5'(waddr); s.wsel = 1'(wsel);
    s.dm_we = 1'(dm_we);   s.dm_rd = 1'(dm_rd); s.dm_addr = 5'(dm_addr);
    s.alu = 2'(alu);       s.done = 1'(dn);     s.ill = 1'(ill);
    s.cnt = 16'(cnt);
    return s;
  endfunction

  task automatic expect_at(input string name, input int c, input snap_t s);
    exp_t e;
    e.name = name; e.cyc = c; e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] ins, output int acc);
    int n;
    @(negedge clk);
    instruction = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) drv_timeout = 1'b1;
    acc = cyc + 1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  // Monitor: compares whenever the DUT shows activity or an expectation is due.
  always @(negedge clk) begin
    exp_t e;
    bit   active;
    act.ready = instr_ready;    act.a = rf_addr_a;          act.b = rf_addr_b;
    act.rf_we = rf_write_enable; act.waddr = rf_write_addr; act.wsel = rf_wdata_sel;
    act.dm_we = dm_write_enable; act.dm_rd = dm_read;       act.dm_addr = dm_addr;
    act.alu = alu_op;           act.done = done;            act.ill = illegal;
    act.cnt = retired_cnt;
    active = dm_read | dm_write_enable | rf_write_enable | done | illegal | (alu_op != 2'b00);
    if (active || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d got=%h", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.s !== act) begin
          errors++;
          $display("FAIL %s cyc=%0d want_cyc=%0d got=%h want=%h", e.name, cyc, e.cyc, act, e.s);
        end
      end
    end
    if (w_done) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wrap_extra_done cyc=%0d cnt=%0d", cyc, w_cnt);
      end else begin
        int want;
        want = wq.pop_front();
        if (int'(w_cnt) != want) begin
          errors++;
          $display("FAIL wrap_cnt cyc=%0d got=%0d want=%0d", cyc, w_cnt, want);
        end
      end
      if (w_last >= 0) begin
        checks++;
        if (cyc - w_last != 2) begin
          errors++;
          $display("FAIL wrap_spacing cyc=%0d got=%0d want=2", cyc, cyc - w_last);
        end
      end
      w_last = cyc;
    end
    if (end_req && !ended) begin
      ended = 1'b1;
      checks++;
      if (exp_q.size() != 0 || wq.size() != 0 || drv_timeout) begin
        errors++;
        $display("FAIL drain pending=%0d wrap_pending=%0d timeout=%0d",
                 exp_q.size(), wq.size(), drv_timeout);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, add_acc, k, n;
    int wexp[5];
    wexp = '{1, 2, 3, 0, 1};
    checks = 0; errors = 0; w_last = -1;
    end_req = 1'b0; drv_timeout = 1'b0; ended = 1'b0;
    rst = 1'b1; instr_valid = 1'b0; instruction = '0;
    w_valid = 1'b0; w_instr = '0;
    repeat (2) @(negedge clk);
    expect_at("reset_state", cyc + 1, mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b0;

    // LW rd=3 imm=7
    issue(enc(0, 3, 0, 0, 7), acc);
    expect_at("lw_mem", acc + 2, mk(0,0,0,0,0,0,0,1,7,0,0,0,0));
    expect_at("lw_wb",  acc + 3, mk(1,0,0,1,3,1,0,0,0,0,1,0,1));

    // ADD then SUB back-to-back; SUB must be accepted 4 cycles after ADD
    issue(enc(2, 4, 1, 2, 0), add_acc);
    expect_at("add_wb", add_acc + 3, mk(1,1,2,1,4,0,0,0,0,0,1,0,2));
    issue(enc(3, 4, 1, 2, 0), acc);
    expect_at("sub_exec", add_acc + 6, mk(0,1,2,0,0,0,0,0,0,1,0,0,2));
    expect_at("sub_wb",   add_acc + 7, mk(1,1,2,1,4,0,0,0,0,0,1,0,3));

    // SW rs2=5 imm=31
    issue(enc(1, 0, 0, 5, 31), acc);
    expect_at("sw_mem", acc + 2, mk(1,0,5,0,0,0,1,0,31,3,1,0,4));

    // ADD to r0: retires without an RF write
    issue(enc(2, 0, 1, 2, 0), acc);
    expect_at("add_rd0", acc + 3, mk(1,1,2,0,0,0,0,0,0,0,1,0,5));

    // opcode 110 is dropped with an illegal pulse
    issue(enc(6, 7, 3, 4, 9), acc);
    expect_at("illegal", acc + 1, mk(1,3,4,0,0,0,0,0,0,0,0,1,5));

    issue(enc(4, 0, 0, 0, 0), acc);
    expect_at("nop", acc + 1, mk(1,0,0,0,0,0,0,0,0,0,1,0,6));

    // Reset while the LW sits in MEM_RD
    issue(enc(0, 3, 0, 0, 7), acc);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    expect_at("rst_during", acc + 2, mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    expect_at("rst_after",  acc + 3, mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Five NOPs on the 2-bit-counter instance with valid held high
    w_instr = enc(4, 0, 0, 0, 0);
    w_valid = 1'b1;
    k = 0; n = 0;
    while (k < 5 && n < 60) begin
      if (w_ready) begin
        wq.push_back(wexp[k]);
        k++;
      end
      @(negedge clk);
      n++;
    end
    if (n >= 60) drv_timeout = 1'b1;
    w_valid = 1'b0;
    repeat (8) @(negedge clk);
    end_req = 1'b1;
    forever @(negedge clk);
  end

endmodule
